// File: rtl/usb_tx_line_encoder.sv
// rtl/usb_tx_line_encoder.sv - USB LS/FS transmit line encoder: SYNC, LSB-first serialise, bit stuffing, NRZI, EOP.
// Optional stuff-bit counter port enabled by USB_TX_STUFF_CNT_EN.
module usb_tx_line_encoder #(
    parameter int DATA_WIDTH   = 8,
    parameter int STUFF_RUN    = 6,
    parameter int SYNC_BITS    = 8,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  dp,
    output logic                  dm,
    output logic                  out_en,
    output logic                  busy,
    output logic                  underrun
`ifdef USB_TX_STUFF_CNT_EN
    ,
    output logic [15:0]           stuff_count
`endif
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int RW = $clog2(STUFF_RUN + 1);
    localparam int SW = $clog2(SYNC_BITS + 1);
    localparam int EW = $clog2(EOP_SE0_BITS + 1);

    localparam logic [BW-1:0] BITS_FULL = BW'(DATA_WIDTH);
    localparam logic [BW-1:0] BITS_LOAD = BW'(DATA_WIDTH - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(STUFF_RUN);
    localparam logic [SW-1:0] SYNC_END  = SW'(SYNC_BITS);
    localparam logic [SW-1:0] SYNC_ONE  = SW'(SYNC_BITS - 1);
    localparam logic [EW-1:0] EOP_END   = EW'(EOP_SE0_BITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    last_q, last_d;
    logic [BW-1:0]           bits_q, bits_d;
    logic [RW-1:0]           run_q, run_d, run_cur;
    logic [SW-1:0]           sync_q, sync_d;
    logic [EW-1:0]           eop_q, eop_d;
    logic                    level_q, level_d;
    logic                    out_en_d, underrun_d, dp_d, dm_d;
    logic                    se0, emit, bit_v, data_step;
`ifdef USB_TX_STUFF_CNT_EN
    logic                    stuffed;
`endif

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        last_d      = last_q;
        bits_d      = bits_q;
        run_d       = run_q;
        run_cur     = run_q;
        sync_d      = sync_q;
        eop_d       = eop_q;
        level_d     = level_q;
        out_en_d    = 1'b1;
        underrun_d  = 1'b0;
        in_ready    = 1'b0;
        se0         = 1'b0;
        emit        = 1'b0;
        bit_v       = 1'b1;
        data_step   = 1'b0;
`ifdef USB_TX_STUFF_CNT_EN
        stuffed     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                out_en_d = 1'b0;
                if (in_valid) begin
                    state_d     = SYNC;
                    shift_d     = in_data;
                    bits_d      = BITS_FULL;
                    last_d      = in_last;
                    hold_full_d = 1'b0;
                    run_d       = '0;
                    sync_d      = SW'(1);
                    out_en_d    = 1'b1;
                    // NRZI starts from J; the first SYNC bit is a 0 unless SYNC is a lone 1
                    level_d     = (SYNC_BITS == 1);
                end
            end
            SYNC: begin
                if (sync_q < SYNC_END) begin
                    emit   = 1'b1;
                    bit_v  = (sync_q == SYNC_ONE);
                    sync_d = sync_q + SW'(1);
                end else begin
                    state_d   = DATA;
                    run_cur   = '0;
                    data_step = 1'b1;
                end
            end
            DATA: begin
                in_ready  = !hold_full_q && !last_q;
                data_step = 1'b1;
            end
            EOP_SE0: begin
                if (eop_q < EOP_END) begin
                    se0   = 1'b1;
                    eop_d = eop_q + EW'(1);
                end else begin
                    state_d = EOP_J;
                    level_d = 1'b1;
                end
            end
            EOP_J: begin
                state_d     = IDLE;
                out_en_d    = 1'b0;
                level_d     = 1'b1;
                hold_full_d = 1'b0;
                last_d      = 1'b0;
                bits_d      = '0;
                run_d       = '0;
                sync_d      = '0;
                eop_d       = '0;
            end
            default: begin
                state_d  = IDLE;
                out_en_d = 1'b0;
                level_d  = 1'b1;
            end
        endcase

        // Priority: starvation aborts before an owed stuff bit; stuff before next payload bit
        if (data_step) begin
            if (bits_q == '0 && !hold_full_q && !last_q) begin
                underrun_d = 1'b1;
                state_d    = EOP_SE0;
                se0        = 1'b1;
                eop_d      = EW'(1);
            end else if (run_cur == RUN_MAX) begin
                emit  = 1'b1;
                bit_v = 1'b0;
                run_d = '0;
`ifdef USB_TX_STUFF_CNT_EN
                stuffed = 1'b1;
`endif
            end else if (bits_q != '0) begin
                emit    = 1'b1;
                bit_v   = shift_q[0];
                shift_d = shift_q >> 1;
                bits_d  = bits_q - BW'(1);
                run_d   = shift_q[0] ? run_cur + RW'(1) : '0;
            end else if (hold_full_q) begin
                emit        = 1'b1;
                bit_v       = hold_q[0];
                shift_d     = hold_q >> 1;
                bits_d      = BITS_LOAD;
                hold_full_d = 1'b0;
                run_d       = hold_q[0] ? run_cur + RW'(1) : '0;
            end else begin
                state_d = EOP_SE0;
                se0     = 1'b1;
                eop_d   = EW'(1);
            end
        end

        if (state_q == DATA && in_valid && in_ready) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
            last_d      = in_last;
        end

        if (emit && !bit_v) begin
            level_d = !level_q;
        end

        dp_d = se0 ? 1'b0 : level_d;
        dm_d = se0 ? 1'b0 : !level_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            last_q      <= 1'b0;
            bits_q      <= '0;
            run_q       <= '0;
            sync_q      <= '0;
            eop_q       <= '0;
            level_q     <= 1'b1;
            dp          <= 1'b1;
            dm          <= 1'b0;
            out_en      <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            last_q      <= last_d;
            bits_q      <= bits_d;
            run_q       <= run_d;
            sync_q      <= sync_d;
            eop_q       <= eop_d;
            level_q     <= level_d;
            dp          <= dp_d;
            dm          <= dm_d;
            out_en      <= out_en_d;
            underrun    <= underrun_d;
        end
    end

`ifdef USB_TX_STUFF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stuff_count <= '0;
        end else if (stuffed && stuff_count != 16'hFFFF) begin
            stuff_count <= stuff_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// tb/tb_usb_tx_line_encoder.sv - directed bench for usb_tx_line_encoder (default and 16-bit/run-3 instances).
module tb_usb_tx_line_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready, dp, dm, out_en, busy, underrun;
    logic [15:0] w_data;
    logic        w_valid, w_last, w_ready, w_dp, w_dm, w_oe, w_busy, w_underrun;
`ifdef USB_TX_STUFF_CNT_EN
    logic [15:0] stuff_count, w_stuff_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    usb_tx_line_encoder u_dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .dp(dp), .dm(dm),
        .out_en(out_en), .busy(busy), .underrun(underrun)
`ifdef USB_TX_STUFF_CNT_EN
        , .stuff_count(stuff_count)
`endif
    );

    usb_tx_line_encoder #(.DATA_WIDTH(16), .STUFF_RUN(3)) u_dut16 (
        .clock(clock), .reset(reset), .in_data(w_data), .in_valid(w_valid),
        .in_last(w_last), .in_ready(w_ready), .dp(w_dp), .dm(w_dm),
        .out_en(w_oe), .busy(w_busy), .underrun(w_underrun)
`ifdef USB_TX_STUFF_CNT_EN
        , .stuff_count(w_stuff_count)
`endif
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] code(input byte c);
        case (c)
            "J":     return 2'b10;
            "K":     return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, " dp"}, 16'(dp), 16'd1);
        chk({tag, " dm"}, 16'(dm), 16'd0);
        chk({tag, " out_en"}, 16'(out_en), 16'd0);
        chk({tag, " busy"}, 16'(busy), 16'd0);
        chk({tag, " underrun"}, 16'(underrun), 16'd0);
        chk({tag, " in_ready"}, 16'(in_ready), 16'd1);
    endtask

    task automatic send(input bit wide, input logic [15:0] data, input bit last);
        if (wide) begin
            w_data = data; w_last = last; w_valid = 1'b1;
        end else begin
            in_data = data[7:0]; in_last = last; in_valid = 1'b1;
        end
        chk("accept in_ready", 16'(wide ? w_ready : in_ready), 16'd1);
        tick;
        w_valid  = 1'b0;
        in_valid = 1'b0;
    endtask

    // Walks one expected line symbol per cycle: J, K, 0 = SE0, U = SE0 with underrun
    task automatic play(input bit wide, input string tag, input string exp);
        for (int i = 0; i < exp.len(); i++) begin
            byte c;
            bit  hs;
            c = exp[i];
            chk($sformatf("%s line[%0d]", tag, i), 16'(wide ? {w_dp, w_dm} : {dp, dm}), 16'(code(c)));
            chk($sformatf("%s out_en[%0d]", tag, i), 16'(wide ? w_oe : out_en), 16'd1);
            chk($sformatf("%s busy[%0d]", tag, i), 16'(wide ? w_busy : busy), 16'd1);
            chk($sformatf("%s underrun[%0d]", tag, i), 16'(wide ? w_underrun : underrun), 16'(c == "U"));
            hs = !wide && in_valid && in_ready;
            tick;
            if (hs) in_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        w_data = '0; w_valid = 1'b0; w_last = 1'b0;
        tick;
        tick;
        check_idle("reset");
        chk("reset w_dp", 16'(w_dp), 16'd1);
        chk("reset w_busy", 16'(w_busy), 16'd0);
        chk("reset w_ready", 16'(w_ready), 16'd1);
`ifdef USB_TX_STUFF_CNT_EN
        chk("reset stuff_count", stuff_count, 16'd0);
`endif
        reset = 1'b0;
        tick;

        send(1'b0, 16'h00, 1'b1);
        play(1'b0, "t00", "KJKJKJKKJKJKJKJK00J");
        check_idle("t00 after");

        send(1'b0, 16'hFF, 1'b1);
        play(1'b0, "tff", "KJKJKJKKKKKKKKJJJ00J");
        check_idle("tff after");
`ifdef USB_TX_STUFF_CNT_EN
        chk("tff stuff_count", stuff_count, 16'd1);
`endif

        send(1'b0, 16'hF0, 1'b0);
        in_data = 8'h03; in_last = 1'b1; in_valid = 1'b1;
        play(1'b0, "tf003", "KJKJKJKKJKJKKKKKKKJKJKJKJ00J");
        check_idle("tf003 after");
`ifdef USB_TX_STUFF_CNT_EN
        chk("tf003 stuff_count", stuff_count, 16'd2);
`endif

        send(1'b0, 16'h01, 1'b0);
        play(1'b0, "tund", "KJKJKJKKKJKJKJKJU0J");
        check_idle("tund after");

        send(1'b0, 16'h00, 1'b1);
        play(1'b0, "trst", "KJKJKJKKJK");
        chk("trst third bit", 16'({dp, dm}), 16'(code("J")));
        reset = 1'b1;
        tick;
        check_idle("trst reset");
        reset = 1'b0;
        tick;
        check_idle("trst idle");
        send(1'b0, 16'h00, 1'b1);
        play(1'b0, "trst2", "KJKJKJKKJKJKJKJK00J");
        check_idle("trst2 after");

        send(1'b1, 16'h0007, 1'b1);
        play(1'b1, "t16", "KJKJKJKKKKKJKJKJKJKJKJKJK00J");
        chk("t16 oe after", 16'(w_oe), 16'd0);
        chk("t16 busy after", 16'(w_busy), 16'd0);
        chk("t16 line after", 16'({w_dp, w_dm}), 16'(code("J")));
`ifdef USB_TX_STUFF_CNT_EN
        chk("t16 stuff_count", w_stuff_count, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_tx_line_encoder.md
Name: usb_tx_line_encoder

Overview:
- Parametrised USB low/full-speed transmit line encoder: accepts packet payload as DATA_WIDTH-bit words over a valid/ready handshake.
- Prepends SYNC, serialises LSB first, inserts stuff zeros after a configurable run of ones, NRZI-encodes, and appends EOP.
- Drives the D+/D- pair plus an output-enable for the bus tristate in the USB host/device transmit path.
- Successor to the standalone NRZI and bit-stuffer: adds word width, configurable run length, stuffing across word boundaries, SYNC/EOP framing and underrun handling.

Parameters:
DATA_WIDTH, 8, payload word width in bits (>=2)
STUFF_RUN, 6, consecutive ones after which a zero is inserted (>=2)
SYNC_BITS, 8, SYNC length in bits: SYNC_BITS-1 zeros then a one, pre-NRZI
EOP_SE0_BITS, 2, SE0 bit times in EOP

Ports:
clock  input  1  bit clock; one line bit per cycle
reset  input  1  synchronous, active-high
in_data  input  DATA_WIDTH  payload word, bit 0 transmitted first
in_valid  input  1  in_data/in_last valid
in_last  input  1  word is the final word of the packet
in_ready  output  1  word accepted on clock edge when in_valid && in_ready
dp  output  1  D+ line (registered)
dm  output  1  D- line (registered)
out_en  output  1  1 = drive the bus, 0 = release (registered)
busy  output  1  1 in any state other than IDLE
underrun  output  1  one-cycle pulse, payload starved mid-packet

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on posedge clock.
- Reset values: dp=1, dm=0 (J), out_en=0, busy=0, underrun=0, in_ready=1. State=IDLE; holding register, run counter and bit counters cleared.
- Reset asserted mid-packet: next edge returns to the reset values. No EOP is emitted and the partial word is discarded.
- Line encoding:
  - J = dp1/dm0, K = dp0/dm1, SE0 = dp0/dm0.
  - NRZI: a 0 toggles the line between J and K; a 1 holds it.
  - NRZI state is J on entering SYNC.
- States:
  - IDLE: out_en=0, in_ready=1.
    - On handshake: word goes straight into the shift register; in_last is latched; go to SYNC.
    - First SYNC bit appears on dp/dm in the cycle after the accepting edge.
  - SYNC: SYNC_BITS cycles, out_en=1, no stuffing. Default pattern on the line is K J K J K J K K.
    - Run counter is cleared on exit; SYNC bits do not count toward stuffing.
  - DATA: one bit per cycle from the shift register, LSB first.
    - Run counter increments on each 1 and clears on each 0.
    - When the counter reaches STUFF_RUN, the next cycle emits a stuffed 0 and the counter clears; the shift register does not advance.
    - The run counter persists across word boundaries.
    - A stuff bit owed after the final payload bit is still emitted before EOP.
  - EOP_SE0: EOP_SE0_BITS cycles of SE0, out_en=1.
  - EOP_J: one cycle of J, out_en=1, then IDLE.
- Payload buffering:
  - In DATA, in_ready = !hold_full && !last_latched.
  - An accepted word goes to the holding register.
  - When the shift register empties, it loads from hold in the same cycle, so no bubble occurs.
  - A handshake in the cycle hold drains is legal: hold is refilled that edge.
- Boundaries:
  - Shift register empty, hold empty, last not latched: underrun pulses for 1 cycle and the block goes to EOP_SE0 (packet aborted, no stuff bit appended).
  - Shift register empty with last latched: go to EOP_SE0 (after any owed stuff bit).
  - in_ready=0 in SYNC, EOP_SE0 and EOP_J.
- Bit-count arithmetic: counters sized $clog2 of their maximum+1; no wrap within legal operation.

Optional Feature:
- Macro USB_TX_STUFF_CNT_EN.
- Defined: adds output port stuff_count [15:0].
  - Reset 0; increments once per inserted stuff bit; saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, one word 0x00 with in_last:
  - dp/dm sequence K J K J K J K K, then J K J K J K J K, then SE0 SE0 J.
  - out_en high exactly 19 cycles; busy falls after EOP_J.
- Word 0xFF with in_last, STUFF_RUN=6:
  - Data phase is 9 cycles: six 1s (line held), stuffed 0 (toggle), two 1s (held); then EOP.
  - With macro defined, stuff_count = 1.
- Words 0xF0 then 0x03 (last), back-to-back:
  - Run of 4+2 ones crosses the boundary; stuff bit after bit 1 of the second word.
  - Total data cycles 17; no bubble between words.
- Word 0x01 not last, then in_valid held low:
  - After 8 data bits, underrun pulses for 1 cycle, then SE0 SE0 J; in_ready returns 1 in IDLE.
- Reset asserted during the third data bit:
  - Next cycle: out_en=0, dp=1, dm=0, busy=0, in_ready=1.
  - A new packet then starts cleanly with SYNC.
- DATA_WIDTH=16, STUFF_RUN=3, word 16'h0007 last:
  - Three 1s, stuffed 0, then 13 zeros.
  - 17 data cycles; correct NRZI toggles throughout.
